// File: rtl/peripheral_irq_flag_ctrl_pkg.sv
// Shared types and defaults for the peripheral interrupt flag controller.
package periph_irq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } state_t;

  localparam int DEF_NUM_SRC     = 4;
  localparam int DEF_ACK_TIMEOUT = 15;
  localparam int TMR_W           = 8;
endpackage

// File: rtl/peripheral_irq_flag_ctrl_if.sv
// Handshake toward the enable stage and the 8259A acknowledge path.
interface peripheral_irq_flag_ctrl_if #(
  parameter int SEL_W = 2
);
  logic             pif;
  logic             pie;
  logic             ir_out;
  logic             inta;
  logic [SEL_W-1:0] vec_out;
  logic             vec_valid;

  modport master (
    input  pif, ir_out, vec_out, vec_valid,
    output pie, inta
  );

  modport slave (
    input  pie, inta,
    output pif, ir_out, vec_out, vec_valid
  );
endinterface

// File: rtl/peripheral_irq_flag_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder with an any-request flag.
module periph_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    // Scan downward so the lowest set index is the last assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = SEL_W'(i);
    end
  end

  assign any = |req;
endmodule

// File: rtl/peripheral_irq_flag_ctrl.sv
// Edge capture into pending bits, fixed-priority request and two-pulse INTA service.
module peripheral_irq_flag_ctrl
  import periph_irq_pkg::*;
#(
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  evt_in,
  input  logic [NUM_SRC-1:0]  evt_mask,
  input  logic                overrun_clr,
  peripheral_irq_flag_ctrl_if.slave irq,
  output logic [NUM_SRC-1:0]  pending,
  output logic                overrun
);
  state_t             state, state_nx;
  logic [NUM_SRC-1:0] evt_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_vec;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   win;
  logic               any_pend;
  logic [TMR_W-1:0]   timer;
  logic [SEL_W-1:0]   vec_q;
  logic               vld_q;

  periph_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_prio (
    .req (pending),
    .idx (win),
    .any (any_pend)
  );

  assign rise    = evt_in & ~evt_prev & ~evt_mask;
  assign clr_vec = (state == ACK2) ? (NUM_SRC'(1) << sel) : '0;

  // evt_prev tracks the line through reset so a level held high at release is not an edge.
  always_ff @(posedge clk) begin
    evt_prev <= evt_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
      if (|(rise & pending & ~clr_vec)) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      timer <= '0;
      vec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_pend) sel <= win;
      if (state == ACK1 && state_nx == ACK1) timer <= timer + 1'b1;
      else                                   timer <= '0;
      if (state == ACK2) vec_q <= sel;
      vld_q <= (state == ACK2);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (any_pend) state_nx = REQ;
      REQ:  if (irq.inta && irq.pie) state_nx = ACK1;
      ACK1: begin
        if (irq.inta)                            state_nx = ACK2;
        else if (timer == TMR_W'(ACK_TIMEOUT))   state_nx = REQ;
      end
      ACK2: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign irq.pif       = (state != IDLE);
  assign irq.ir_out    = (state == REQ) && irq.pie;
  assign irq.vec_out   = vec_q;
  assign irq.vec_valid = vld_q;
endmodule
